pe_seq_ctrl: RTL and testbench
==============================

PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameters: ADDR_W, default 8, width of buffer addresses. LEN_W, default 8, width of length configuration fields.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  job start request; sampled only in IDLE.
REQ-005 cfg_vec_num  input  LEN_W  number of 512-bit vector pairs per output (N).
REQ-006 cfg_out_num  input  LEN_W  number of outputs in the job (M).
REQ-007 cfg_nbase / cfg_wbase  input  ADDR_W each  neuron and weight buffer base addresses.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-009 done  output  1  one-cycle pulse at job completion.
REQ-010 nram_ren / nram_addr  output  1 / ADDR_W  neuron buffer read; data returns on nram_rdata (input, 512) exactly 1 cycle after ren.
REQ-011 wram_ren / wram_addr  output  1 / ADDR_W  weight buffer read; data returns on wram_rdata (input, 512) exactly 1 cycle after ren.
REQ-012 pe_neuron / pe_weight  output  512 each  PE operands; combinational pass-through of nram_rdata / wram_rdata.
REQ-013 pe_vld / pe_ctl  output  1 / 2  PE issue strobe; ctl[0] = clear accumulator, ctl[1] = last vector of the output.
REQ-014 pe_result / pe_vld_o  input  32 / 1  PE accumulated sum and its valid; pe_vld_o arrives 1 cycle after the pe_vld carrying ctl[1]=1.
REQ-015 res_data / res_vld / res_rdy  output 32 / output 1 / input 1  result stream with a valid/ready handshake.

Function
REQ-016 States: IDLE, RUN, WAIT_RES, HOLD, FIN.
REQ-017 IDLE: start=1 latches all cfg_* inputs; M=0 or N=0 goes to FIN with no buffer reads; otherwise goes to RUN.
REQ-018 RUN: nram_ren and wram_ren assert together for exactly N consecutive cycles, then the state goes to WAIT_RES.
REQ-019 Neuron address for vector v (0..N-1) = nbase+v, identical for every output.
REQ-020 Weight address = wbase plus a running pointer that increments once per read and is never reset between outputs (output o, vector v -> wbase+o*N+v).
REQ-021 All address arithmetic wraps modulo 2^ADDR_W.
REQ-022 pe_vld = ren delayed 1 cycle.
REQ-023 pe_ctl is delayed with pe_vld; ctl[0]=1 only on v=0, ctl[1]=1 only on v=N-1, both set when N=1, pe_ctl=0 whenever pe_vld=0.
REQ-024 WAIT_RES: on pe_vld_o=1, res_data is loaded with pe_result and res_vld is set. The state then goes to HOLD if outputs remain, else to FIN.
REQ-025 res_vld and res_data hold stable until the cycle res_vld&res_rdy=1; res_vld then clears unless a new capture occurs in the same cycle.
REQ-026 HOLD: goes to RUN for the next output only in a cycle where res_vld=0 or res_rdy=1, so no capture ever overwrites an unaccepted result.
REQ-027 FIN: waits until res_vld=0 or the final handshake occurs. done is pulsed in the following cycle, busy drops in that same cycle, and the state returns to IDLE.
REQ-028 start while busy is ignored; cfg_* changes after acceptance have no effect.
REQ-029 pe_vld_o outside WAIT_RES is ignored.

Reset
REQ-030 rst_n low forces IDLE, busy=0, done=0, res_vld=0, res_data=0, all ren=0, pe_vld=0, pe_ctl=0, addresses=0, counters=0. This holds immediately and also when rst_n is asserted mid-job; the aborted job produces no further outputs.

Verification
REQ-031 N=4, M=1, nbase=0x10, wbase=0x40, res_rdy=1, start at cycle 0:
- ren at cycles 1-4, nram_addr 0x10-0x13, wram_addr 0x40-0x43.
- pe_vld at cycles 2-5, pe_ctl 01,00,00,10.
- res_vld=1 at cycle 7; done at cycle 8.
REQ-032 N=1, M=3, wbase=0xFE: single-vector outputs with pe_ctl=11, wram_addr 0xFE, 0xFF, 0x00 (wrap), three results in order, one done pulse.
REQ-033 N=2, M=2, res_rdy=0 for 10 cycles after the first res_vld: second RUN does not start, res_data stays stable; after res_rdy=1 the second output completes normally.
REQ-034 cfg_out_num=0 with start: no ren, no res_vld, done pulses once; a start during busy of a normal job produces no second job.
REQ-035 rst_n low during RUN of N=8: all outputs at reset values at once; the next start after release runs a full job correctly.

Source files
------------

// File: rtl/pe_seq_ctrl.sv
// Sequencer for a dot-product PE: streams N neuron/weight vector pairs per output
// for M outputs, and hands each accumulated result out on a valid/ready stream.
module pe_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_vec_num,
    input  logic [LEN_W-1:0]  cfg_out_num,
    input  logic [ADDR_W-1:0] cfg_nbase,
    input  logic [ADDR_W-1:0] cfg_wbase,
    output logic              busy,
    output logic              done,
    output logic              nram_ren,
    output logic [ADDR_W-1:0] nram_addr,
    input  logic [511:0]      nram_rdata,
    output logic              wram_ren,
    output logic [ADDR_W-1:0] wram_addr,
    input  logic [511:0]      wram_rdata,
    output logic [511:0]      pe_neuron,
    output logic [511:0]      pe_weight,
    output logic              pe_vld,
    output logic [1:0]        pe_ctl,
    input  logic [31:0]       pe_result,
    input  logic              pe_vld_o,
    output logic [31:0]       res_data,
    output logic              res_vld,
    input  logic              res_rdy,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WAIT_RES = 3'd2,
        HOLD     = 3'd3,
        FIN      = 3'd4
    } state_t;

    state_t              state;
    logic                ren;
    logic [LEN_W-1:0]    vec_num_q;
    logic [LEN_W-1:0]    out_num_q;
    logic [ADDR_W-1:0]   nbase_q;
    logic [ADDR_W-1:0]   wnext;
    logic [LEN_W-1:0]    vcnt;
    logic [LEN_W-1:0]    ocnt;
    logic [LEN_W-1:0]    vec_last;
    logic [LEN_W-1:0]    out_last;
    logic                res_free;

    assign vec_last  = vec_num_q - 1'b1;
    assign out_last  = out_num_q - 1'b1;
    assign nram_ren  = ren;
    assign wram_ren  = ren;
    assign pe_neuron = nram_rdata;
    assign pe_weight = wram_rdata;
    assign dbg_state = state;

    // Result stream: a beat transfers on a rising edge where res_vld && res_rdy;
    // res_vld/res_data never change while res_vld=1 and res_rdy=0.
    assign res_free = !res_vld || res_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ren       <= 1'b0;
            nram_addr <= '0;
            wram_addr <= '0;
            pe_vld    <= 1'b0;
            pe_ctl    <= 2'b00;
            res_data  <= '0;
            res_vld   <= 1'b0;
            vec_num_q <= '0;
            out_num_q <= '0;
            nbase_q   <= '0;
            wnext     <= '0;
            vcnt      <= '0;
            ocnt      <= '0;
        end else begin
            done   <= 1'b0;
            pe_vld <= ren;
            pe_ctl <= ren ? {vcnt == vec_last, vcnt == '0} : 2'b00;
            if (res_vld && res_rdy)
                res_vld <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        vec_num_q <= cfg_vec_num;
                        out_num_q <= cfg_out_num;
                        nbase_q   <= cfg_nbase;
                        busy      <= 1'b1;
                        vcnt      <= '0;
                        ocnt      <= '0;
                        if (cfg_vec_num == '0 || cfg_out_num == '0) begin
                            state <= FIN;
                        end else begin
                            state     <= RUN;
                            ren       <= 1'b1;
                            nram_addr <= cfg_nbase;
                            wram_addr <= cfg_wbase;
                            wnext     <= cfg_wbase + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (vcnt == vec_last) begin
                        ren   <= 1'b0;
                        state <= WAIT_RES;
                    end else begin
                        vcnt      <= vcnt + 1'b1;
                        nram_addr <= nram_addr + 1'b1;
                        wram_addr <= wnext;
                        wnext     <= wnext + 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (pe_vld_o) begin
                        res_data <= pe_result;
                        res_vld  <= 1'b1;
                        if (ocnt == out_last) begin
                            state <= FIN;
                        end else begin
                            ocnt  <= ocnt + 1'b1;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // The weight pointer keeps running across outputs.
                    if (res_free) begin
                        state     <= RUN;
                        ren       <= 1'b1;
                        vcnt      <= '0;
                        nram_addr <= nbase_q;
                        wram_addr <= wnext;
                        wnext     <= wnext + 1'b1;
                    end
                end
                FIN: begin
                    if (res_free) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: buffer and PE models around the DUT, a scoreboard of
// expected addresses/results, a job table, and hand-written timing/reset sequences.
module tb_pe_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   cfg_vec_num, cfg_out_num, cfg_nbase, cfg_wbase;
    logic         busy, done;
    logic         nram_ren, wram_ren;
    logic [7:0]   nram_addr, wram_addr;
    logic [511:0] nram_rdata, wram_rdata, pe_neuron, pe_weight;
    logic         pe_vld;
    logic [1:0]   pe_ctl;
    logic [31:0]  pe_result;
    logic         pe_vld_o, pe_vld_model, inject;
    logic [31:0]  res_data;
    logic         res_vld, res_rdy;
    logic [2:0]   dbg_state;
    logic [31:0]  acc;

    int checks = 0;
    int errors = 0;
    int reads = 0, results = 0, dones = 0;
    logic       hold_prev = 1'b0;
    logic [31:0] hold_data = '0;

    logic [7:0]  exp_naddr_q[$];
    logic [7:0]  exp_waddr_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pe_seq_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_vec_num(cfg_vec_num), .cfg_out_num(cfg_out_num),
        .cfg_nbase(cfg_nbase), .cfg_wbase(cfg_wbase),
        .busy(busy), .done(done),
        .nram_ren(nram_ren), .nram_addr(nram_addr), .nram_rdata(nram_rdata),
        .wram_ren(wram_ren), .wram_addr(wram_addr), .wram_rdata(wram_rdata),
        .pe_neuron(pe_neuron), .pe_weight(pe_weight),
        .pe_vld(pe_vld), .pe_ctl(pe_ctl),
        .pe_result(pe_result), .pe_vld_o(pe_vld_o),
        .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] nword(logic [7:0] a);
        return 32'h0001_0000 + {24'h0, a};
    endfunction

    function automatic logic [31:0] wword(logic [7:0] a);
        return 32'h0000_0300 + {24'h0, a} * 32'd7;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Buffer models: one-cycle read latency.
    always @(posedge clk) begin
        if (nram_ren) nram_rdata <= {16{nword(nram_addr)}};
        if (wram_ren) wram_rdata <= {16{wword(wram_addr)}};
    end

    // PE model: multiply-accumulate on the low word, result one cycle after the last vector.
    assign pe_vld_o = pe_vld_model | inject;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            pe_result    <= '0;
            pe_vld_model <= 1'b0;
        end else begin
            pe_vld_model <= 1'b0;
            if (pe_vld) begin
                logic [31:0] a;
                a = (pe_ctl[0] ? 32'h0 : acc) + pe_neuron[31:0] * pe_weight[31:0];
                acc <= a;
                if (pe_ctl[1]) begin
                    pe_result    <= a;
                    pe_vld_model <= 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (nram_ren || wram_ren) begin
                reads++;
                check("ren_pair", nram_ren, wram_ren);
                check("no_read_while_result_pending", res_vld, 0);
                if (exp_naddr_q.size() == 0 || exp_waddr_q.size() == 0)
                    fail("unexpected_read");
                else begin
                    check("nram_addr", nram_addr, exp_naddr_q.pop_front());
                    check("wram_addr", wram_addr, exp_waddr_q.pop_front());
                end
            end
            if (!pe_vld) check("pe_ctl_idle", pe_ctl, 0);
            if (hold_prev) begin
                check("res_vld_hold", res_vld, 1);
                check("res_data_hold", res_data, hold_data);
            end
            if (res_vld && res_rdy) begin
                results++;
                if (exp_q.size() == 0) fail("unexpected_result");
                else check("res_data", res_data, exp_q.pop_front());
            end
            if (done) dones++;
            hold_prev = res_vld && !res_rdy;
            hold_data = res_data;
        end
    end

    function automatic logic [31:0] exp_sum(int n, int o, logic [7:0] nb, logic [7:0] wb);
        logic [31:0] s;
        s = '0;
        for (int v = 0; v < n; v++)
            s += nword(nb + 8'(v)) * wword(wb + 8'(o * n + v));
        return s;
    endfunction

    task automatic push_job(int n, int m, logic [7:0] nb, logic [7:0] wb);
        if (n == 0 || m == 0) return;
        for (int o = 0; o < m; o++) begin
            for (int v = 0; v < n; v++) begin
                exp_naddr_q.push_back(nb + 8'(v));
                exp_waddr_q.push_back(wb + 8'(o * n + v));
            end
            exp_q.push_back(exp_sum(n, o, nb, wb));
        end
    endtask

    task automatic drive_start(int n, int m, logic [7:0] nb, logic [7:0] wb);
        @(posedge clk); #1;
        cfg_vec_num = 8'(n);
        cfg_out_num = 8'(m);
        cfg_nbase   = nb;
        cfg_wbase   = wb;
        start       = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
    endtask

    task automatic run_job(int n, int m, logic [7:0] nb, logic [7:0] wb, int stall, bit dbl,
                           int exp_reads, int exp_results);
        int r0, q0, d0, cyc, st;
        bit seen;
        r0 = reads; q0 = results; d0 = dones;
        st = 0; seen = 0; cyc = 0;
        res_rdy = 1'b1;
        push_job(n, m, nb, wb);
        drive_start(n, m, nb, wb);
        if (dbl) begin
            cfg_vec_num = 8'd7; cfg_out_num = 8'd5; cfg_nbase = 8'h99; cfg_wbase = 8'h11;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (dones == d0 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (!seen && stall > 0 && res_vld) begin
                seen = 1;
                res_rdy = 1'b0;
            end else if (seen && !res_rdy) begin
                st++;
                if (st == stall) begin
                    check("stall_no_next_run", reads - r0, n);
                    check("stall_res_vld", res_vld, 1);
                    res_rdy = 1'b1;
                end
            end
        end
        if (cyc >= 3000) fail("job_timeout");
        repeat (6) @(posedge clk);
        #1;
        check("job_reads", reads - r0, exp_reads);
        check("job_results", results - q0, exp_results);
        check("job_done_pulses", dones - d0, 1);
        check("job_busy_after", busy, 0);
        check("job_exp_left", exp_q.size() + exp_naddr_q.size(), 0);
    endtask

    typedef struct {
        int         n;
        int         m;
        logic [7:0] nb;
        logic [7:0] wb;
        int         stall;
        bit         dbl;
        int         exp_reads;
        int         exp_results;
    } job_t;

    typedef struct {
        logic       ren;
        logic [7:0] na;
        logic [7:0] wa;
        logic       pv;
        logic [1:0] ctl;
        logic       rv;
        logic       dn;
        logic       bz;
    } cyc_t;

    initial begin
        job_t jobs[8];
        cyc_t tim[9];
        int   d0, r0, q0;

        jobs[0] = '{4, 1, 8'h10, 8'h40, 0,  0, 4, 1};
        jobs[1] = '{1, 3, 8'h00, 8'hFE, 0,  0, 3, 3};
        jobs[2] = '{2, 2, 8'h20, 8'h80, 10, 0, 4, 2};
        jobs[3] = '{3, 0, 8'h20, 8'h80, 0,  0, 0, 0};
        jobs[4] = '{0, 3, 8'h20, 8'h80, 0,  0, 0, 0};
        jobs[5] = '{3, 4, 8'hFE, 8'hF8, 0,  1, 12, 4};
        jobs[6] = '{5, 2, 8'h30, 8'hC0, 3,  0, 10, 2};
        jobs[7] = '{1, 1, 8'hFF, 8'hFF, 2,  1, 1, 1};

        tim[0] = '{1, 8'h10, 8'h40, 0, 2'b00, 0, 0, 1};
        tim[1] = '{1, 8'h11, 8'h41, 1, 2'b01, 0, 0, 1};
        tim[2] = '{1, 8'h12, 8'h42, 1, 2'b00, 0, 0, 1};
        tim[3] = '{1, 8'h13, 8'h43, 1, 2'b00, 0, 0, 1};
        tim[4] = '{0, 8'h00, 8'h00, 1, 2'b10, 0, 0, 1};
        tim[5] = '{0, 8'h00, 8'h00, 0, 2'b00, 0, 0, 1};
        tim[6] = '{0, 8'h00, 8'h00, 0, 2'b00, 1, 0, 1};
        tim[7] = '{0, 8'h00, 8'h00, 0, 2'b00, 0, 1, 0};
        tim[8] = '{0, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0};

        rst_n = 1'b0; start = 1'b0; res_rdy = 1'b1; inject = 1'b0;
        cfg_vec_num = '0; cfg_out_num = '0; cfg_nbase = '0; cfg_wbase = '0;
        nram_rdata = '0; wram_rdata = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ren", {nram_ren, wram_ren}, 0);
        check("rst_res", {res_vld, res_data}, 0);
        check("rst_pe", {pe_vld, pe_ctl}, 0);
        check("rst_addr", {nram_addr, wram_addr}, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cycle-exact single-output job: start during cycle 0.
        push_job(4, 1, 8'h10, 8'h40);
        drive_start(4, 1, 8'h10, 8'h40);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("c%0d_ren", k + 1), nram_ren, tim[k].ren);
            if (tim[k].ren) begin
                check($sformatf("c%0d_naddr", k + 1), nram_addr, tim[k].na);
                check($sformatf("c%0d_waddr", k + 1), wram_addr, tim[k].wa);
            end
            check($sformatf("c%0d_pe_vld", k + 1), pe_vld, tim[k].pv);
            check($sformatf("c%0d_pe_ctl", k + 1), pe_ctl, tim[k].ctl);
            check($sformatf("c%0d_res_vld", k + 1), res_vld, tim[k].rv);
            check($sformatf("c%0d_done", k + 1), done, tim[k].dn);
            check($sformatf("c%0d_busy", k + 1), busy, tim[k].bz);
        end
        check("timing_exp_left", exp_q.size(), 0);

        for (int j = 0; j < 8; j++)
            run_job(jobs[j].n, jobs[j].m, jobs[j].nb, jobs[j].wb, jobs[j].stall,
                    jobs[j].dbl, jobs[j].exp_reads, jobs[j].exp_results);

        for (int j = 0; j < 4; j++) begin
            int n, m, st;
            n  = $urandom_range(1, 6);
            m  = $urandom_range(1, 4);
            st = $urandom_range(0, 4);
            run_job(n, m, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), st, 0, n * m, m);
        end

        // A stray PE valid while idle must not produce a result.
        q0 = results;
        @(posedge clk); #1; inject = 1'b1;
        @(posedge clk); #1; inject = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stray_pe_vld_o_res_vld", res_vld, 0);
        check("stray_pe_vld_o_results", results - q0, 0);

        // Reset in the middle of an N=8 job.
        push_job(8, 2, 8'h50, 8'h60);
        drive_start(8, 2, 8'h50, 8'h60);
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_ren", nram_ren, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ren", {nram_ren, wram_ren}, 0);
        check("abort_pe", {pe_vld, pe_ctl}, 0);
        check("abort_addr", {nram_addr, wram_addr}, 0);
        check("abort_res", {res_vld, res_data, done}, 0);
        check("abort_state", dbg_state, 0);
        exp_q.delete();
        exp_naddr_q.delete();
        exp_waddr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = dones; r0 = reads; q0 = results;
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_more_reads", reads - r0, 0);
        check("abort_no_more_results", results - q0, 0);
        check("abort_no_done", dones - d0, 0);
        run_job(8, 2, 8'h50, 8'h60, 0, 0, 16, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
